// File: rtl/ballot_unit.sv
`timescale 1ns/1ps
// ballot_unit: front-panel ballot conditioner placed directly ahead of voting_machine.
// It synchronises and debounces the raw buttons. It runs a select-then-confirm ballot
// sequence with timeout, cancel and post-commit lockout.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   enable_vote  - polling open (synchronous level)
//   btn_A/B/C    - raw candidate buttons, active-high, asynchronous
//   btn_confirm  - raw confirm button, active-high, asynchronous
//   btn_cancel   - raw cancel button, active-high, asynchronous
//   vote_A/B/C   - one-cycle selection pulse
//   confirm_vote - one-cycle commit pulse
//   selection    - 00 none, 01 A, 10 B, 11 C
//   busy         - high while HELD, COMMIT or LOCKOUT
//   timeout      - one-cycle pulse when an unconfirmed selection expires
//   multi_press  - one-cycle pulse when two or more candidate presses coincide
//   ballot_count - committed ballots, saturating at 127
module ballot_unit #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 64,
   parameter int unsigned LOCKOUT_CYCLES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable_vote,
   input  logic       btn_A,
   input  logic       btn_B,
   input  logic       btn_C,
   input  logic       btn_confirm,
   input  logic       btn_cancel,
   output logic       vote_A,
   output logic       vote_B,
   output logic       vote_C,
   output logic       confirm_vote,
   output logic [1:0] selection,
   output logic       busy,
   output logic       timeout,
   output logic       multi_press,
   output logic [6:0] ballot_count
);

   localparam int unsigned NB   = 5;
   localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam int unsigned CW   = 7;
   localparam int unsigned I_CONF = 3;
   localparam int unsigned I_CANC = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_HELD    = 3'd2,
      S_COMMIT  = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   // Button vector: [0]=A [1]=B [2]=C [3]=confirm [4]=cancel
   logic [NB-1:0] raw_c;
   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;
   logic [NB-1:0] deb;
   logic [NB-1:0] deb_q;
   logic [DW-1:0] deb_cnt [NB];
   logic [NB-1:0] ev_c;

   logic [2:0]    cand_c;
   logic [1:0]    cand_sel_c;
   logic          cand_one_c;
   logic          cand_multi_c;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] hold_cnt;
   logic [TW-1:0] hold_nxt;
   logic [LW-1:0] lock_cnt;
   logic [LW-1:0] lock_nxt;
   logic [1:0]    sel_nxt;
   logic [2:0]    vote_nxt;
   logic          confirm_nxt;
   logic          timeout_nxt;
   logic          multi_nxt;
   logic          busy_nxt;
   logic [CW-1:0] count_nxt;

   assign raw_c = {btn_cancel, btn_confirm, btn_C, btn_B, btn_A};

   // Two-flop synchroniser plus per-button debounce counter.
   // The counter advances only while the synchronised level disagrees with the accepted level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int unsigned i = 0; i < NB; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw_c;
         sync2 <= sync1;
         deb_q <= deb;
         for (int unsigned i = 0; i < NB; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb[i]     <= ~deb[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Press events are rising edges of the debounced level; releases are silent.
   assign ev_c   = deb & ~deb_q;
   assign cand_c = ev_c[2:0];

   // Candidate decode: a non-zero code means exactly one candidate press.
   always_comb begin
      cand_sel_c = 2'd0;
      case (cand_c)
         3'b001:  cand_sel_c = 2'd1;
         3'b010:  cand_sel_c = 2'd2;
         3'b100:  cand_sel_c = 2'd3;
         default: cand_sel_c = 2'd0;
      endcase
   end

   assign cand_one_c   = (cand_sel_c != 2'd0);
   assign cand_multi_c = (cand_c != 3'b000) && !cand_one_c;

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         lock_cnt     <= '0;
         selection    <= 2'd0;
         vote_A       <= 1'b0;
         vote_B       <= 1'b0;
         vote_C       <= 1'b0;
         confirm_vote <= 1'b0;
         timeout      <= 1'b0;
         multi_press  <= 1'b0;
         busy         <= 1'b0;
         ballot_count <= '0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_nxt;
         lock_cnt     <= lock_nxt;
         selection    <= sel_nxt;
         vote_A       <= vote_nxt[0];
         vote_B       <= vote_nxt[1];
         vote_C       <= vote_nxt[2];
         confirm_vote <= confirm_nxt;
         timeout      <= timeout_nxt;
         multi_press  <= multi_nxt;
         busy         <= busy_nxt;
         ballot_count <= count_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      lock_nxt    = lock_cnt;
      sel_nxt     = selection;
      vote_nxt    = 3'b000;
      confirm_nxt = 1'b0;
      timeout_nxt = 1'b0;
      multi_nxt   = 1'b0;
      count_nxt   = ballot_count;

      case (state)
         S_IDLE: begin
            if (enable_vote) begin
               state_nxt = S_SELECT;
            end
         end

         S_SELECT: begin
            multi_nxt = cand_multi_c;
            if (!enable_vote) begin
               state_nxt = S_IDLE;
               sel_nxt   = 2'd0;
            end else if (cand_one_c) begin
               sel_nxt   = cand_sel_c;
               vote_nxt  = cand_c;
               hold_nxt  = '0;
               state_nxt = S_HELD;
            end
         end

         // Priority: enable drop > cancel > confirm > candidate change > expiry.
         // A repeat of the current candidate falls through and leaves the timer running.
         S_HELD: begin
            multi_nxt = cand_multi_c;
            if (!enable_vote) begin
               state_nxt = S_IDLE;
               sel_nxt   = 2'd0;
            end else if (ev_c[I_CANC]) begin
               state_nxt = S_SELECT;
               sel_nxt   = 2'd0;
            end else if (ev_c[I_CONF]) begin
               state_nxt = S_COMMIT;
            end else if (cand_one_c && (cand_sel_c != selection)) begin
               sel_nxt  = cand_sel_c;
               vote_nxt = cand_c;
               hold_nxt = '0;
            end else if (hold_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               timeout_nxt = 1'b1;
               sel_nxt     = 2'd0;
               state_nxt   = S_SELECT;
            end else begin
               hold_nxt = hold_cnt + TW'(1);
            end
         end

         // Commit pulse leaves on the exit edge, one cycle behind a vote pulse.
         S_COMMIT: begin
            confirm_nxt = 1'b1;
            sel_nxt     = 2'd0;
            lock_nxt    = '0;
            if (ballot_count != {CW{1'b1}}) begin
               count_nxt = ballot_count + CW'(1);
            end
            state_nxt = enable_vote ? S_LOCKOUT : S_IDLE;
         end

         S_LOCKOUT: begin
            if (!enable_vote) begin
               state_nxt = S_IDLE;
            end else if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
               state_nxt = S_SELECT;
            end else begin
               lock_nxt = lock_cnt + LW'(1);
            end
         end

         default: begin
            state_nxt = S_IDLE;
            sel_nxt   = 2'd0;
         end
      endcase

      busy_nxt = (state_nxt == S_HELD) || (state_nxt == S_COMMIT) || (state_nxt == S_LOCKOUT);
   end

endmodule

// File: doc/ballot_unit.md
# ballot_unit

Front-panel ballot conditioner that sits directly upstream of `voting_machine`. It synchronises and debounces the raw voter buttons and enforces a select-then-confirm ballot sequence with timeout, cancel and post-commit lockout. It drives `voting_machine` with clean single-cycle `vote_A/B/C` and `confirm_vote` pulses. It also reports the current selection and a count of committed ballots for the panel display.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples needed to accept a button level change (≥2).
- `TIMEOUT_CYCLES`, 64: cycles a selection may stay unconfirmed before it is discarded (≥2).
- `LOCKOUT_CYCLES`, 8: dead time after each commit during which all presses are ignored (≥1).
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0). Every register clears immediately on assertion.
- `enable_vote` in 1: polling open, from controller; synchronous level.
- `btn_A`, `btn_B`, `btn_C` in 1 each: raw asynchronous candidate buttons, active-high.
- `btn_confirm`, `btn_cancel` in 1 each: raw asynchronous buttons, active-high.
- `vote_A`, `vote_B`, `vote_C` out 1 each: one-cycle selection pulse to `voting_machine`.
- `confirm_vote` out 1: one-cycle commit pulse to `voting_machine`.
- `selection` out 2: 00 none, 01 A, 10 B, 11 C.
- `busy` out 1: high in HELD, COMMIT, LOCKOUT.
- `timeout` out 1: one-cycle pulse when a selection expires.
- `multi_press` out 1: one-cycle pulse when two or more candidate presses land in the same cycle.
- `ballot_count` out 7: committed ballots, saturating at 127.

## Operation
- **Input path, per button:**
  - A 2-flop synchroniser feeds a debounce counter.
  - The counter increments while the synchronised value ≠ the debounced level, and clears when they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press event is a rising edge of the debounced level. Release generates nothing.
  - A pulse shorter than `DEBOUNCE_CYCLES` samples never generates an event.
- **FSM states:** IDLE, SELECT, HELD, COMMIT, LOCKOUT. Reset state is IDLE.
  - **IDLE:**
    - If `enable_vote`=1, go to SELECT.
    - Any event that arrives while in IDLE is dropped.
  - **SELECT:**
    - If exactly one candidate event arrives: set `selection`, pulse matching `vote_X`, go to HELD, clear the timeout counter.
    - Confirm or cancel events are ignored.
  - **HELD** (event priority is cancel > confirm > candidate):
    - Cancel: clear `selection`, go to SELECT, no pulses.
    - Confirm: go to COMMIT.
    - A single candidate event for a different candidate: update `selection`, pulse new `vote_X`, restart timeout.
    - A candidate event for the same candidate: ignored.
    - When the timeout counter reaches `TIMEOUT_CYCLES` with no accepted event: pulse `timeout`, clear `selection`, go to SELECT.
  - **COMMIT:**
    - For exactly one cycle: `confirm_vote`=1, `ballot_count`+1 (saturating), `selection` cleared.
    - Then go to LOCKOUT.
  - **LOCKOUT:**
    - Lasts `LOCKOUT_CYCLES` cycles; all events are dropped.
    - Then go to SELECT, or to IDLE if `enable_vote`=0.
    - A button held through lockout produces no event on exit.
- **Multiple candidates:**
  - Two or more candidate events in one cycle (in SELECT or HELD): all are ignored and `multi_press` pulses.
  - In HELD, cancel/confirm still take priority in that same cycle.
- **`enable_vote` falling:**
  - From SELECT or HELD: next state is IDLE, `selection` cleared, no `confirm_vote`.
  - COMMIT still completes, then enters IDLE instead of LOCKOUT.
  - LOCKOUT goes to IDLE immediately.
- **Output exclusivity:**
  - At most one of `vote_A/B/C`/`confirm_vote` is high in any cycle.
  - A `vote_X` pulse and `confirm_vote` are never in the same cycle.

## Timing
- **Reset values:** every output 0. Also state IDLE, synchronisers/debounced levels/counters 0, `ballot_count` 0.
- **Output timing:** all outputs are registered. `selection`, `busy` and `ballot_count` update on the same edge as the associated pulse.
- **Press latency:**
  - Edge 0 is the first rising edge sampling a raw button high.
  - The debounced level rises after edge `DEBOUNCE_CYCLES`+1.
  - The response pulse is high in the cycle following edge `DEBOUNCE_CYCLES`+2, i.e. 6 cycles with defaults.
- **Confirm-to-commit:** confirm event → `confirm_vote` high in the cycle after the COMMIT entry edge (one extra cycle versus a `vote_X` pulse).
- **Back-to-back commits:** minimum spacing is `LOCKOUT_CYCLES` + 2 + press latency.
- **Reset mid-ballot:** any pulse in flight is cut. No `confirm_vote` is generated for an unconfirmed selection after reset.

## Test plan
- **Reset/enable:**
  - Stimulus: `reset`=0 at 3 ns mid-cycle; release, `enable_vote`=1, press A for 10 cycles.
  - Response: all outputs 0 during reset. `vote_A` single pulse 6 cycles after edge 0, `selection`=01, `busy`=1.
- **Bounce:**
  - Stimulus: `btn_B` toggling every 2 cycles for 20 cycles, then held.
  - Response: exactly one `vote_B` pulse, issued only after a stable run of `DEBOUNCE_CYCLES` samples.
- **Full ballot:**
  - Stimulus: press C, then confirm; repeat 3 ballots.
  - Response: three `vote_C` + `confirm_vote` pairs, `ballot_count`=3, presses during LOCKOUT produce nothing.
- **Change/cancel/timeout:**
  - Change: A then B gives `vote_A` then `vote_B`, `selection`=10.
  - Cancel: gives `selection`=00 and no confirm.
  - Timeout: select A and wait 64 cycles; `timeout` pulses, no `confirm_vote`.
- **Simultaneous events:**
  - A+B same cycle in SELECT: `multi_press` pulse, state unchanged.
  - Confirm+cancel same cycle in HELD: cancel wins.
- **Enable drop/saturation:**
  - `enable_vote`→0 in HELD: IDLE, `selection`=00, no commit.
  - 130 ballots: `ballot_count` holds at 127.
